// File: rtl/instr_stream_loader_pkg.sv
// Shared state encoding, default widths and segment-dispatch helper for the
// run-length instruction loader.
package instr_stream_loader_pkg;

  localparam int DATA_W_DEF = 3;
  localparam int ADDR_W_DEF = 16;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_FETCH,
    S_READ,
    S_END
  } state_t;

  // Where the loader goes once a segment is taken or the current one runs out.
  function automatic state_t next_after_seg(input logic count_nz,
                                            input logic last,
                                            input logic total_nz);
    if (count_nz)      return S_WRITE;
    else if (!last)    return S_FETCH;
    else if (total_nz) return S_READ;
    else               return S_END;
  endfunction

endpackage

// File: rtl/instr_stream_loader_seg_counter.sv
// Loadable down-counter with zero/one flags; a load wins over a decrement
// so back-to-back segments can reload on their predecessor's final cycle.
module seg_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero,
  output logic         one
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)                      cnt <= '0;
    else if (load)                cnt <= load_val;
    else if (dec && cnt != '0)    cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);
  assign one  = (cnt == W'(1));

endmodule

// File: rtl/instr_stream_loader.sv
// Run-length program loader: expands (code, count) segments into SRAM writes,
// then replays the program as a read burst. LOADER_CHECKSUM_EN adds chk[7:0].
module instr_stream_loader
  import instr_stream_loader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_code,
  input  logic [CNT_W-1:0]  cmd_count,
  input  logic              cmd_last,
  output logic              wr,
  output logic              rd,
  output logic [DATA_W-1:0] wr_data,
  output logic              done,
  output logic              ovf,
  output logic [ADDR_W:0]   total
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [7:0]        chk
`endif
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  state_t            state, next_state;
  logic [DATA_W-1:0] code_q;
  logic              last_q;
  logic              accept, sat;
  logic              rem_zero, rem_one, rem_last;
  logic              rd_zero, rd_one, rd_last;
  logic              rem_load, rd_load;
  logic [ADDR_W:0]   total_next;

  assign accept     = cmd_valid && cmd_ready;
  assign sat        = (total == DEPTH);
  assign rem_last   = rem_one || rem_zero;
  assign rd_last    = rd_one || rd_zero;
  assign total_next = (state == S_WRITE && !sat) ? total + (ADDR_W+1)'(1) : total;
  assign rem_load   = accept && (cmd_count != '0);
  assign rd_load    = (next_state == S_READ) && (state != S_READ);

  seg_counter #(.W(CNT_W)) u_rem (
    .clk      (clk),
    .rst      (rst),
    .load     (rem_load),
    .load_val (cmd_count),
    .dec      (state == S_WRITE),
    .zero     (rem_zero),
    .one      (rem_one)
  );

  // The burst length is the saturated word count, so it never exceeds the SRAM.
  seg_counter #(.W(ADDR_W+1)) u_burst (
    .clk      (clk),
    .rst      (rst),
    .load     (rd_load),
    .load_val (total_next),
    .dec      (state == S_READ),
    .zero     (rd_zero),
    .one      (rd_one)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:  if (accept) next_state = next_after_seg(|cmd_count, cmd_last, 1'b0);
      S_WRITE: begin
        if (rem_last) begin
          if (last_q)      next_state = next_after_seg(1'b0, 1'b1, |total_next);
          else if (accept) next_state = next_after_seg(|cmd_count, cmd_last, |total_next);
          else             next_state = S_FETCH;
        end
      end
      S_FETCH: if (accept) next_state = next_after_seg(|cmd_count, cmd_last, |total);
      S_READ:  if (rd_last) next_state = S_END;
      S_END:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    wr        = 1'b0;
    rd        = 1'b0;
    done      = 1'b0;
    wr_data   = '0;
    unique case (state)
      S_IDLE, S_FETCH: cmd_ready = 1'b1;
      S_WRITE: begin
        cmd_ready = rem_last && !last_q;
        wr        = !sat;
      end
      S_READ:  rd   = 1'b1;
      S_END:   done = 1'b1;
      default: ;
    endcase
    if (wr) wr_data = code_q;
  end

  // A program starts with an accept in IDLE; totals are cleared on that edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      code_q <= '0;
      last_q <= 1'b0;
      total  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (accept) begin
        code_q <= cmd_code;
        last_q <= cmd_last;
      end
      if (state == S_IDLE && accept) begin
        total <= '0;
        ovf   <= 1'b0;
      end else begin
        total <= total_next;
        if (state == S_WRITE && sat) ovf <= 1'b1;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst)                        chk <= '0;
    else if (state == S_IDLE && accept) chk <= '0;
    else if (wr)                    chk <= chk + 8'(wr_data);
  end
`endif

endmodule
